// File: rtl/rr_arbiter_enc_if.sv
// Request/grant bundle between one router output port's requesters and its arbiter.
// master drives requests and the tail/ready handshake; slave returns the held grant.
interface rr_arbiter_enc_if #(
  parameter int SIZE = 8
);
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [SIZE-1:0]  request;
  logic             tail_release;
  logic             grant_ready;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_xfer;

  modport master (
    output request, tail_release, grant_ready,
    input  grant_valid, grant_idx, grant_xfer
  );

  modport slave (
    input  request, tail_release, grant_ready,
    output grant_valid, grant_idx, grant_xfer
  );
endinterface

// File: rtl/rr_arbiter_enc.sv
// Packet-level round-robin arbiter with registered binary grant; ARB_FAST_REARB_EN removes the inter-packet bubble.
// Latency: request->grant_valid 1 cycle; the grant stays locked until tail_release coincides with grant_ready.
module rr_arbiter_enc #(
  parameter int SIZE = 8
) (
  input  logic            clock_i,
  input  logic            reset_n_i,
  rr_arbiter_enc_if.slave arb
);
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] grant_idx_q;
  logic             grant_valid_q;

  logic             tail_xfer;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] arb_ptr;
  logic [SIZE-1:0]  req_eff;
  logic             win_vld;
  logic [IDX_W-1:0] win;

  assign tail_xfer = (state_q == LOCKED) & arb.tail_release & arb.grant_ready;
  // Wrap at SIZE so a non-power-of-two port count never points past the last requester.
  assign next_ptr  = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + IDX_W'(1);

`ifdef ARB_FAST_REARB_EN
  assign arb_ptr = tail_xfer ? next_ptr : ptr_q;
  assign req_eff = tail_xfer ? (arb.request & ~(SIZE'(1) << grant_idx_q)) : arb.request;
`else
  assign arb_ptr = ptr_q;
  assign req_eff = arb.request;
`endif

  always_comb begin
    int cand;
    win_vld = 1'b0;
    win     = '0;
    cand    = 0;
    for (int i = 0; i < SIZE; i++) begin
      cand = int'(arb_ptr) + i;
      if (cand >= SIZE) cand = cand - SIZE;
      if (!win_vld && req_eff[cand[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win     = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            grant_idx_q   <= win;
            grant_valid_q <= 1'b1;
            state_q       <= LOCKED;
          end
        end
        LOCKED: begin
          if (tail_xfer) begin
            ptr_q <= next_ptr;
`ifdef ARB_FAST_REARB_EN
            if (win_vld) begin
              grant_idx_q <= win;
            end else begin
              grant_valid_q <= 1'b0;
              state_q       <= IDLE;
            end
`else
            grant_valid_q <= 1'b0;
            state_q       <= IDLE;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb.grant_valid = grant_valid_q;
  assign arb.grant_idx   = grant_idx_q;
  assign arb.grant_xfer  = grant_valid_q & arb.grant_ready;
endmodule

// File: tb/tb_rr_arbiter_enc.sv
// Scoreboard bench for rr_arbiter_enc: an 8-way and a 5-way instance driven by directed vectors;
// stimulus pushes expected winners, per-instance monitors pop them at each new grant.
module tb_rr_arbiter_enc;
  logic clk = 1'b0;
  logic rst_n;
  logic rst5_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_q[$];
  int   exp5_q[$];
  logic pv8 = 1'b0, pl8 = 1'b0, pv5 = 1'b0, pl5 = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter_enc_if #(.SIZE(8)) if8 ();
  rr_arbiter_enc_if #(.SIZE(5)) if5 ();

  rr_arbiter_enc #(.SIZE(8)) u8 (.clock_i(clk), .reset_n_i(rst_n),  .arb(if8.slave));
  rr_arbiter_enc #(.SIZE(5)) u5 (.clock_i(clk), .reset_n_i(rst5_n), .arb(if5.slave));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input bit s5);
    int n = 0;
    while (!(s5 ? if5.grant_valid : if8.grant_valid) && n < 20) begin
      tick();
      n++;
    end
    check(s5 ? "grant5_timeout" : "grant8_timeout",
          int'(s5 ? if5.grant_valid : if8.grant_valid), 1);
  endtask

  task automatic release_pkt(input bit s5, input logic [7:0] req_next);
    if (s5) begin
      if5.request = req_next[4:0]; if5.tail_release = 1'b1; if5.grant_ready = 1'b1;
    end else begin
      if8.request = req_next;      if8.tail_release = 1'b1; if8.grant_ready = 1'b1;
    end
    tick();
    if5.tail_release = 1'b0; if5.grant_ready = 1'b0;
    if8.tail_release = 1'b0; if8.grant_ready = 1'b0;
  endtask

  task automatic reset8();
    rst_n = 1'b0;
    if8.request = '0; if8.tail_release = 1'b0; if8.grant_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // A grant is new when valid rises or when the previous cycle handed over on a tail.
  always @(negedge clk) begin
    if (!rst_n) begin
      pv8 = 1'b0; pl8 = 1'b0;
    end else begin
      if (if8.grant_valid && (!pv8 || pl8)) begin
        if (exp_q.size() == 0) check("grant8_unexpected", int'(if8.grant_idx), -1);
        else                   check("grant8_idx", int'(if8.grant_idx), exp_q.pop_front());
      end
      pv8 = if8.grant_valid;
      pl8 = if8.tail_release & if8.grant_xfer;
    end
  end

  always @(negedge clk) begin
    if (!rst5_n) begin
      pv5 = 1'b0; pl5 = 1'b0;
    end else begin
      if (if5.grant_valid && (!pv5 || pl5)) begin
        if (exp5_q.size() == 0) check("grant5_unexpected", int'(if5.grant_idx), -1);
        else                    check("grant5_idx", int'(if5.grant_idx), exp5_q.pop_front());
      end
      pv5 = if5.grant_valid;
      pl5 = if5.tail_release & if5.grant_xfer;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    rst5_n = 1'b0;
    if8.request = '0; if8.tail_release = 1'b0; if8.grant_ready = 1'b1;
    if5.request = '0; if5.tail_release = 1'b0; if5.grant_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", int'(if8.grant_valid), 0);
    check("rst_idx",   int'(if8.grant_idx),   0);
    check("rst_xfer",  int'(if8.grant_xfer),  0);
    if8.grant_ready = 1'b0;
    rst_n = 1'b1;

    // Idle with no requests
    for (int c = 0; c < 5; c++) begin
      tick();
      check("idle_valid", int'(if8.grant_valid), 0);
      check("idle_idx",   int'(if8.grant_idx),   0);
    end

    // 8'h24 from ptr 0: 2 wins, then 5 after the release
    if8.request = 8'h24;
    exp_q.push_back(2);
    tick();
    check("latency_valid", int'(if8.grant_valid), 1);
    tick();
    exp_q.push_back(5);
    release_pkt(1'b0, 8'h24);
`ifdef ARB_FAST_REARB_EN
    check("handover_valid", int'(if8.grant_valid), 1);
    check("handover_idx",   int'(if8.grant_idx),   5);
`else
    check("bubble_valid", int'(if8.grant_valid), 0);
`endif
    wait_grant(1'b0);
    tick();
    release_pkt(1'b0, 8'h00);
    check("drain_valid", int'(if8.grant_valid), 0);

    // All requesting: full rotation 0..7 then wrap to 0
    reset8();
    if8.request = 8'hFF;
    for (int k = 0; k < 8; k++) exp_q.push_back(k);
    exp_q.push_back(0);
    for (int k = 0; k < 9; k++) begin
      wait_grant(1'b0);
      tick();
      release_pkt(1'b0, (k == 8) ? 8'h00 : 8'hFF);
    end

    // Lock on 3 survives a dropped request and a release without ready
    if8.request = 8'h08;
    exp_q.push_back(3);
    wait_grant(1'b0);
    if8.request = 8'h01;
    if8.tail_release = 1'b1;
    if8.grant_ready  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("stall_valid", int'(if8.grant_valid), 1);
      check("stall_idx",   int'(if8.grant_idx),   3);
      check("stall_xfer",  int'(if8.grant_xfer),  0);
    end
    if8.request = 8'h00;
    if8.grant_ready = 1'b1;
    #1;
    check("tail_xfer", int'(if8.grant_xfer), 1);
    tick();
    check("tail_valid", int'(if8.grant_valid), 0);

    // Release and ready while idle do nothing
    tick();
    tick();
    check("idle_release_valid", int'(if8.grant_valid), 0);
    if8.tail_release = 1'b0;
    if8.grant_ready  = 1'b0;
    if8.request = 8'h11;
    exp_q.push_back(4);
    wait_grant(1'b0);
    tick();
    release_pkt(1'b0, 8'h00);

    // Reset mid-packet on 6 drops the grant at once and clears the pointer
    if8.request = 8'h40;
    exp_q.push_back(6);
    wait_grant(1'b0);
    tick();
    if8.grant_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(if8.grant_valid), 0);
    check("midrst_xfer",  int'(if8.grant_xfer),  0);
    check("midrst_idx",   int'(if8.grant_idx),   0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    if8.grant_ready = 1'b0;
    if8.request = 8'h41;
    exp_q.push_back(0);
    wait_grant(1'b0);
    tick();
    release_pkt(1'b0, 8'h00);

    // 8'h09: 0 then 3 then back to 0; lone requester always re-arbitrates through idle
    reset8();
    if8.request = 8'h09;
    exp_q.push_back(0);
    exp_q.push_back(3);
    wait_grant(1'b0);
    tick();
    release_pkt(1'b0, 8'h09);
`ifdef ARB_FAST_REARB_EN
    check("fast_valid", int'(if8.grant_valid), 1);
    check("fast_idx",   int'(if8.grant_idx),   3);
`else
    check("rearb_bubble", int'(if8.grant_valid), 0);
`endif
    wait_grant(1'b0);
    tick();
    exp_q.push_back(0);
    release_pkt(1'b0, 8'h09);
    wait_grant(1'b0);
    tick();
    release_pkt(1'b0, 8'h00);
    if8.request = 8'h08;
    exp_q.push_back(3);
    wait_grant(1'b0);
    tick();
    release_pkt(1'b0, 8'h08);
    check("solo_gap_valid", int'(if8.grant_valid), 0);
    exp_q.push_back(3);
    wait_grant(1'b0);
    tick();
    release_pkt(1'b0, 8'h00);

    // SIZE=5: rotation must wrap at 5, not 8
    rst5_n = 1'b1;
    if5.request = 5'h1F;
    for (int k = 0; k < 5; k++) exp5_q.push_back(k);
    exp5_q.push_back(0);
    for (int k = 0; k < 6; k++) begin
      wait_grant(1'b1);
      tick();
      release_pkt(1'b1, (k == 5) ? 8'h00 : 8'h1F);
    end

    tick();
    tick();
    tick();
    check("sb8_empty", exp_q.size(),  0);
    check("sb5_empty", exp5_q.size(), 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
